// File: rtl/trace_line_arbiter.sv
`default_nettype none
// trace_line_arbiter: line-atomic round-robin merge of four trace-character streams.
// Rev 1.0 - initial release.
module trace_line_arbiter #(
  parameter int TIMEOUT  = 16,
  parameter int MAX_LINE = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_char,
  output logic [3:0]  req_ready,
  output logic        out_valid,
  output logic [7:0]  out_char,
  output logic [1:0]  out_src,
  output logic        line_done,
  output logic        abort
);

  localparam logic [7:0] C_HASH     = 8'h23;
  localparam logic [7:0] C_LF       = 8'h0A;
  localparam logic [7:0] C_TIMEOUT  = 8'(TIMEOUT);
  localparam logic [7:0] C_MAX_LINE = 8'(MAX_LINE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] grant;
  logic [1:0] last_grant;
  logic [7:0] len_cnt;
  logic [7:0] idle_cnt;

  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic [7:0] cur_char;
  logic       xfer;
  logic [7:0] len_inc;
  logic [7:0] idle_inc;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    winner = last_grant + 2'd1;
    cand   = last_grant;
    found  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = cand + 2'd1;
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign cur_char = req_char[{grant, 3'b000} +: 8];
  assign xfer     = (state == PASS) && req_valid[grant];
  assign len_inc  = (len_cnt  == 8'hFF) ? len_cnt  : len_cnt  + 8'd1;
  assign idle_inc = (idle_cnt == 8'hFF) ? idle_cnt : idle_cnt + 8'd1;

  always_comb begin
    req_ready = 4'b0000;
    if (state == PASS && !reset) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 2'd0;
      last_grant <= 2'd3;
      len_cnt    <= 8'd0;
      idle_cnt   <= 8'd0;
      out_valid  <= 1'b0;
      out_char   <= 8'h00;
      out_src    <= 2'd0;
      line_done  <= 1'b0;
      abort      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      line_done <= 1'b0;
      abort     <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant    <= winner;
            len_cnt  <= 8'd0;
            idle_cnt <= 8'd0;
            state    <= PASS;
          end
        end
        PASS: begin
          if (xfer) begin
            out_valid <= 1'b1;
            out_char  <= cur_char;
            out_src   <= grant;
            len_cnt   <= len_inc;
            idle_cnt  <= 8'd0;
            if (cur_char == C_HASH) begin
              line_done  <= 1'b1;
              last_grant <= grant;
              state      <= IDLE;
            end else if (len_inc == C_MAX_LINE) begin
              state <= ABORT;
            end
          end else begin
            idle_cnt <= idle_inc;
            if (idle_inc >= C_TIMEOUT) state <= ABORT;
          end
        end
        ABORT: begin
          // Newline flushes whatever partial line the checker is holding.
          out_valid  <= 1'b1;
          out_char   <= C_LF;
          out_src    <= grant;
          abort      <= 1'b1;
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
